apb_master_bridge: RTL
======================

# apb_master_bridge

Single-outstanding APB initiator that turns a valid/ready command stream into APB setup/access transfers and returns the result on a valid/ready response stream. It drives the register-side APB slaves in the peripheral subsystem (e.g. the UART register block) from a local controller or a debug-bridge front end. It also guards the bus with a PREADY timeout so that a hung slave cannot stall the controller.

## Interface
Parameters:
- APB_DATA_WIDTH, 32, APB data width; multiple of 8.
- APB_ADDR_WIDTH, 32, APB address width.
- TIMEOUT_CYCLE, 6, maximum ACCESS-phase cycles waited for PREADY; must be ≥1.

Ports:
- apb_clk_in  input  1  clock; all logic on rising edge.
- apb_rst_in  input  1  asynchronous, active-high reset.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  command accepted when high with cmd_valid_in.
- cmd_write_in  input  1  1 = write, 0 = read.
- cmd_addr_in  input  APB_ADDR_WIDTH  byte address.
- cmd_wdata_in  input  APB_DATA_WIDTH  write data.
- cmd_strb_in  input  APB_DATA_WIDTH/8  byte strobes; only with APB_WSTRB_EN.
- rsp_valid_out  output  1  response present.
- rsp_ready_in  input  1  response consumed.
- rsp_rdata_out  output  APB_DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_out  output  1  slave error, misalignment, or timeout.
- rsp_timeout_out  output  1  error cause was timeout.
- apb_addr_out  output  APB_ADDR_WIDTH  PADDR.
- apb_psel_out  output  1  PSEL.
- apb_penable_out  output  1  PENABLE.
- apb_write_out  output  1  PWRITE.
- apb_wdata_out  output  APB_DATA_WIDTH  PWDATA.
- apb_strb_out  output  APB_DATA_WIDTH/8  PSTRB; only with APB_WSTRB_EN.
- apb_rdata_in  input  APB_DATA_WIDTH  PRDATA.
- apb_ready_in  input  1  PREADY.
- apb_slverr_in  input  1  PSLVERR.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready_out=1.
  - On handshake, register write, addr, wdata and strb.
  - If addr[1:0]≠0, go to RESP with err=1 and timeout=0; no bus cycle is issued.
  - Otherwise go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. Timeout counter (width $clog2(TIMEOUT_CYCLE+1)) counts ACCESS cycles starting at 1.
  - If apb_ready_in is sampled high: capture rdata (reads only, else 0) and err=apb_slverr_in, then go to RESP.
  - Else if counter==TIMEOUT_CYCLE: go to RESP with err=1, timeout=1, rdata=0. PSEL and PENABLE drop on the next edge.
- RESP:
  - rsp_valid_out=1, psel=0, penable=0.
  - Response fields are held stable until rsp_ready_in=1, then go to IDLE.
- apb_addr_out, apb_write_out and apb_wdata_out hold the last command's values outside transfers; they are never X.
- If PREADY and the timeout limit coincide in the same cycle, PREADY wins and the transfer is a normal completion.
- Only one transaction is in flight. cmd_ready_out=0 in every state other than IDLE.

## Timing
- Reset values: cmd_ready_out=1 (it is low only while reset is asserted), and every other output is 0.
- Reset asserted mid-transfer immediately clears psel, penable and rsp_valid. The in-flight command is dropped.
- Command handshake at edge N:
  - SETUP in cycle N+1.
  - ACCESS from cycle N+2.
  - With zero wait states, rsp_valid_out=1 in cycle N+3.
- Each PREADY wait state adds one cycle.
- A timeout abort gives rsp_valid_out=1 at N+3+TIMEOUT_CYCLE-1.
- A misaligned command gives rsp_valid_out=1 at N+1.
- Back-to-back commands: the next command can be accepted at the earliest one cycle after the response handshake. Minimum period is 4 cycles.

## Configuration
- APB_WSTRB_EN defined:
  - cmd_strb_in and apb_strb_out exist.
  - Writes drive the registered strobes.
  - Reads drive apb_strb_out=0.
- APB_WSTRB_EN undefined: the strobe ports are absent, and slaves treat every write as a full-word write.

## Test plan
- Write of 0xA5 to 0xA0300000 with zero wait states -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3 with err=0 and rdata=0.
- Read from 0xA0300014, slave holds PREADY low 3 cycles and returns 0x00000060 -> rsp_valid at N+6, rdata=0x60, err=0.
- Read where PREADY never rises, TIMEOUT_CYCLE=6 -> 6 ACCESS cycles, then PSEL=0 and response with err=1, timeout=1, rdata=0.
- Write to 0xA0300002 -> no PSEL pulse, rsp_valid at N+1 with err=1 and timeout=0.
- PSLVERR=1 with PREADY on the first ACCESS cycle while rsp_ready_in is held low 5 cycles -> response stable for 5 cycles with err=1, timeout=0, and cmd_ready_out=0 throughout.
- apb_rst_in pulsed during ACCESS -> PSEL/PENABLE are 0 in the same cycle, state returns to IDLE, and a following write completes normally. With APB_WSTRB_EN, strobe 4'b0010 appears on apb_strb_out.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB initiator with a PREADY timeout.
// Optional byte strobes are enabled by defining APB_WSTRB_EN.
module apb_master_bridge #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLE  = 6
) (
    input  logic                        apb_clk_in,
    input  logic                        apb_rst_in,
    input  logic                        cmd_valid_in,
    output logic                        cmd_ready_out,
    input  logic                        cmd_write_in,
    input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
    input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
`ifdef APB_WSTRB_EN
    input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
    output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
`endif
    output logic                        rsp_valid_out,
    input  logic                        rsp_ready_in,
    output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
    output logic                        rsp_err_out,
    output logic                        rsp_timeout_out,
    output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
    output logic                        apb_psel_out,
    output logic                        apb_penable_out,
    output logic                        apb_write_out,
    output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
    input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
    input  logic                        apb_ready_in,
    input  logic                        apb_slverr_in
);
    localparam int CW = $clog2(TIMEOUT_CYCLE + 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic timeout_hit, accept, misaligned;
    assign accept      = state == IDLE && cmd_valid_in;
    assign misaligned  = |cmd_addr_in[1:0];
    assign timeout_hit = cnt == CW'(TIMEOUT_CYCLE);
    assign cmd_ready_out   = state == IDLE && !apb_rst_in;
    assign apb_psel_out    = state == SETUP || state == ACCESS;
    assign apb_penable_out = state == ACCESS;
    assign rsp_valid_out   = state == RESP;
    always_ff @(posedge apb_clk_in or posedge apb_rst_in)
        if (apb_rst_in) state <= IDLE;
        else            state <= state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = cmd_valid_in ? (misaligned ? RESP : SETUP) : IDLE;
            SETUP:   state_n = ACCESS;
            ACCESS:  state_n = (apb_ready_in || timeout_hit) ? RESP : ACCESS;
            RESP:    state_n = rsp_ready_in ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // PREADY takes priority over the timeout limit when both occur together
    always_ff @(posedge apb_clk_in or posedge apb_rst_in)
        if (apb_rst_in) begin
            apb_write_out   <= 1'b0;
            apb_addr_out    <= '0;
            apb_wdata_out   <= '0;
            rsp_rdata_out   <= '0;
            rsp_err_out     <= 1'b0;
            rsp_timeout_out <= 1'b0;
            cnt             <= '0;
        end else begin
            if (accept) begin
                apb_write_out   <= cmd_write_in;
                apb_addr_out    <= cmd_addr_in;
                apb_wdata_out   <= cmd_wdata_in;
                rsp_rdata_out   <= '0;
                rsp_err_out     <= misaligned;
                rsp_timeout_out <= 1'b0;
            end
            if (state == SETUP) cnt <= CW'(1);
            if (state == ACCESS) begin
                if (apb_ready_in) begin
                    rsp_rdata_out <= (apb_write_out || apb_slverr_in) ? '0 : apb_rdata_in;
                    rsp_err_out   <= apb_slverr_in;
                end else if (timeout_hit) begin
                    rsp_err_out     <= 1'b1;
                    rsp_timeout_out <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
`ifdef APB_WSTRB_EN
    logic [APB_DATA_WIDTH/8-1:0] strb_q;
    always_ff @(posedge apb_clk_in or posedge apb_rst_in)
        if (apb_rst_in)  strb_q <= '0;
        else if (accept) strb_q <= cmd_strb_in;
    assign apb_strb_out = apb_write_out ? strb_q : '0;
`endif
endmodule
